// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: requester, grant and memory bus between the two ports and the shared data memory
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: CPU-priority data memory arbiter with a starvation guard for the debug port
module dmem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input logic                clk,
    input logic                reset,
    dmem_port_arbiter_if.slave bus
);
    localparam logic [3:0] MAX = 4'(MAX_STREAK);

    logic [3:0] starve_cnt;
    logic       rd_cpu;
    logic       rd_dbg;
    logic       dbg_turn;

    // same-cycle grant, memory mux and read-data steering
    always_comb begin
        dbg_turn       = starve_cnt == MAX;
        bus.cpu_gnt    = ~reset & bus.cpu_req & (~bus.dbg_req | ~dbg_turn);
        bus.dbg_gnt    = ~reset & bus.dbg_req & (~bus.cpu_req | dbg_turn);
        bus.cpu_stall  = bus.cpu_req & ~bus.cpu_gnt;
        bus.mem_we     = (bus.cpu_gnt & bus.cpu_we) | (bus.dbg_gnt & bus.dbg_we);
        bus.mem_addr   = bus.cpu_gnt ? bus.cpu_addr  : bus.dbg_gnt ? bus.dbg_addr  : '0;
        bus.mem_wdata  = bus.cpu_gnt ? bus.cpu_wdata : bus.dbg_gnt ? bus.dbg_wdata : '0;
        bus.cpu_rvalid = rd_cpu;
        bus.dbg_rvalid = rd_dbg;
        bus.cpu_rdata  = rd_cpu ? bus.mem_rdata : '0;
        bus.dbg_rdata  = rd_dbg ? bus.mem_rdata : '0;
    end

    // track who owns next cycle's read data and how long debug has been locked out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            rd_cpu     <= 1'b0;
            rd_dbg     <= 1'b0;
        end else begin
            rd_cpu     <= bus.cpu_gnt & ~bus.cpu_we;
            rd_dbg     <= bus.dbg_gnt & ~bus.dbg_we;
            starve_cnt <= (~bus.dbg_req | bus.dbg_gnt) ? 4'd0 :
                          (bus.cpu_gnt & ~dbg_turn) ? starve_cnt + 4'd1 : starve_cnt;
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and random traffic checked against a behavioural arbiter/memory model
module tb_dmem_port_arbiter;
    localparam int MS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_clr = 1'b1;
    logic [31:0] mem [64];

    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(MS)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // simple one-cycle-latency memory device
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            bus.mem_rdata <= mem[bus.mem_addr[7:2]];
            if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    int checks = 0;
    int errors = 0;
    int streak = 0;
    bit pc = 0, pd = 0;
    logic [31:0] pdata = '0;
    logic [31:0] refm [bit [31:0]];
    logic last_ec = 0, last_ed = 0, seen_cg = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [31:0] rdref(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : 32'h0;
    endfunction

    task automatic cyc(input logic rs, input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd, input bit rm);
        logic ec, ed, ewe, erc, erd;
        logic [31:0] eaddr, ewd;
        reset = rs;
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
        if (rm) begin
            #1 chk("pre_rst_gnt", {31'b0, bus.cpu_gnt}, 32'd1);
            reset = 1'b1;
            #1 chk("rst_gnt_drop", {31'b0, bus.cpu_gnt}, 32'd0);
            chk("rst_we_drop", {31'b0, bus.mem_we}, 32'd0);
        end
        @(negedge clk);
        if (reset) begin
            ec = 0; ed = 0;
        end else begin
            ed = dr && (!cr || streak >= MS);
            ec = cr && !ed;
        end
        ewe = (ec && cw) || (ed && dw);
        eaddr = ec ? ca : ed ? da : 32'h0;
        ewd = ec ? cd : ed ? dd : 32'h0;
        erc = !reset && pc;
        erd = !reset && pd;
        chk("cpu_gnt", {31'b0, bus.cpu_gnt}, {31'b0, ec});
        chk("dbg_gnt", {31'b0, bus.dbg_gnt}, {31'b0, ed});
        chk("cpu_stall", {31'b0, bus.cpu_stall}, {31'b0, cr && !ec});
        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, ewe});
        chk("mem_addr", bus.mem_addr, eaddr);
        chk("mem_wdata", bus.mem_wdata, ewd);
        chk("cpu_rvalid", {31'b0, bus.cpu_rvalid}, {31'b0, erc});
        chk("dbg_rvalid", {31'b0, bus.dbg_rvalid}, {31'b0, erd});
        chk("cpu_rdata", bus.cpu_rdata, erc ? pdata : 32'h0);
        chk("dbg_rdata", bus.dbg_rdata, erd ? pdata : 32'h0);
        seen_cg = bus.cpu_gnt;
        last_ec = ec;
        last_ed = ed;
        @(posedge clk);
        if (reset) begin
            streak = 0; pc = 0; pd = 0;
        end else begin
            pc = ec && !cw;
            pd = ed && !dw;
            if (pc) pdata = rdref(ca);
            if (pd) pdata = rdref(da);
            if (ewe) refm[eaddr] = ewd;
            if (!dr || ed) streak = 0;
            else if (ec && streak < MS) streak++;
        end
        #1;
    endtask

    task automatic idle(input logic rs);
        cyc(rs, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic both_rd(input logic [4:0] pat, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, 32'h20, 0, 1, 0, 32'h24, 0, 0);
            chk(nm, {31'b0, seen_cg}, {31'b0, pat[4 - (i % 5)]});
        end
    endtask

    initial begin
        logic cr = 0, cw = 0, dr = 0, dw = 0, rs;
        logic [31:0] ca = 0, cd = 0, da = 0, dd = 0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
        @(posedge clk); #1;
        mem_clr = 0;
        cyc(1, 1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0);
        chk("reset_rvalid", {31'b0, bus.cpu_rvalid | bus.dbg_rvalid}, 32'd0);
        idle(0);
        cyc(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        chk("cpu_load_rvalid", {31'b0, bus.cpu_rvalid}, 32'd1);
        chk("cpu_load_data", bus.cpu_rdata, 32'hDEADBEEF);
        idle(0);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h13, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
        chk("dbg_load_rvalid", {31'b0, bus.dbg_rvalid}, 32'd1);
        chk("dbg_load_data", bus.dbg_rdata, 32'h13);
        idle(0);
        both_rd(5'b11110, 10, "contention_pattern");
        idle(0);
        cyc(0, 1, 1, 32'h4, 32'h11112222, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h8, 32'h33334444, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 32'h4, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h8, 0, 0);
        chk("b2b_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("b2b_dbg_rdata", bus.dbg_rdata, 32'h33334444);
        idle(0);
        both_rd(5'b11110, 3, "pre_reset_streak");
        cyc(0, 1, 0, 32'h4, 0, 1, 0, 32'h24, 0, 1);
        chk("post_rst_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
        both_rd(5'b11110, 5, "post_reset_pattern");
        idle(0);
        both_rd(5'b11110, 2, "drop_pre");
        cyc(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        both_rd(5'b11110, 5, "drop_pattern");
        idle(0);
        for (int n = 0; n < 3000; n++) begin
            if (!(cr && !last_ec)) begin
                cr = $urandom_range(0, 3) != 0;
                cw = $urandom_range(0, 1) == 1;
                ca = {24'h0, 6'($urandom), 2'b00};
                cd = $urandom;
            end
            if (!(dr && !last_ed)) begin
                dr = $urandom_range(0, 2) != 0;
                dw = $urandom_range(0, 1) == 1;
                da = {24'h0, 6'($urandom), 2'b00};
                dd = $urandom;
            end
            rs = $urandom_range(0, 99) == 0;
            cyc(rs, cr, cw, ca, cd, dr, dw, da, dd, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter that shares the single-port data memory between the rv32i core's load/store path and a debug/loader port. It grants at most one access per cycle, muxes address, write data and write enable onto the memory, and routes one-cycle-latency read data back to the requester that issued the read. A starvation counter bounds how long the debug port can be locked out, and the core gets a stall indication whenever it loses arbitration.

## Interface
Parameters:
- ADDR_W, 32, address width of both requesters and memory
- DATA_W, 32, data width
- MAX_STREAK, 4, consecutive CPU grants allowed while debug is waiting (legal 1..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cpu_req  in  1  core requests an access this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  core address (byte address, passed through unchanged)
- cpu_wdata  in  DATA_W  core store data (already lane-formatted by the store logic)
- cpu_gnt  out  1  core access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  read data for the core is on cpu_rdata
- cpu_rdata  out  DATA_W  read data to the load logic
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  same meaning for the debug port
- dbg_gnt  out  1  debug access accepted this cycle
- dbg_rvalid  out  1  read data for debug is on dbg_rdata
- dbg_rdata  out  DATA_W  read data to the debug port
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the address

## Operation
- Handshake: a transfer occurs in any cycle where req & gnt are both high. The requester holds req, we, addr and wdata stable until granted. Grant is combinational in the same cycle.
- Arbitration, evaluated each cycle:
  - Only one requester active: it wins.
  - Both active: CPU wins unless starve_cnt == MAX_STREAK, in which case debug wins.
- starve_cnt (4-bit) update:
  - Increments on each CPU grant while dbg_req is high.
  - Clears on any debug grant, or on any cycle with dbg_req low.
  - Saturates at MAX_STREAK and never wraps.
- Memory outputs:
  - Winner's addr and wdata are driven to mem_addr and mem_wdata.
  - mem_we = winner's we & gnt.
  - With no winner: mem_we = 0, mem_addr and mem_wdata = 0.
- Read return:
  - The registered flags rd_cpu and rd_dbg are set on the edge that ends a granted read (we = 0) by that requester. Otherwise they clear.
  - cpu_rvalid = rd_cpu; dbg_rvalid = rd_dbg. At most one is high.
  - cpu_rdata and dbg_rdata both pass mem_rdata through combinationally, each qualified only by its rvalid.
- Back-to-back reads from either port are supported, one per cycle; no other outstanding-request limit.
- Writes produce no response; completion is the grant cycle.

## Timing
- Grant latency: 0 cycles (same cycle as req when winning).
- Read latency: 1 cycle. A read granted in cycle N gives rvalid high and data valid in cycle N+1.
- Write takes effect at the rising edge ending the grant cycle.
- Worst-case debug wait: MAX_STREAK CPU grants, then granted on the next cycle. With the default, debug is granted by its 5th cycle of continuous request.
- Reset asserted, at any time:
  - Asynchronously clears starve_cnt, rd_cpu and rd_dbg.
  - While reset is high: cpu_gnt, dbg_gnt and mem_we are forced 0, and cpu_stall = cpu_req.
  - A read granted in the cycle reset rises returns no rvalid.
- Reset values: all gnt and rvalid outputs 0; mem_we 0; mem_addr, mem_wdata, cpu_rdata and dbg_rdata follow their combinational paths.
- Simultaneous CPU write and debug read to the same address in the same cycle: only the winner proceeds. The loser retries and observes the winner's result.

## Test plan
- CPU-only traffic:
  - Stimulus: store 0xDEADBEEF to 0x10, then load from 0x10.
  - Response: cpu_gnt high both cycles; cpu_rvalid high the cycle after the load with cpu_rdata = 0xDEADBEEF; dbg_rvalid stays 0.
- Debug-only traffic:
  - Stimulus: dbg writes 0x0000_0013 to 0x0, then reads it back.
  - Response: dbg_gnt immediate; dbg_rdata = 0x13 one cycle later; cpu_stall 0.
- Contention with starvation guard (MAX_STREAK = 4):
  - Stimulus: cpu_req and dbg_req held high continuously.
  - Response: grants repeat CPU×4, DBG×1. cpu_stall is high exactly on the DBG cycles. starve_cnt sequence is 0,1,2,3,4,0.
- Back-to-back mixed reads:
  - Stimulus: CPU read 0x4 in cycle N, debug read 0x8 in N+1.
  - Response: cpu_rvalid only in N+1, dbg_rvalid only in N+2, each with the correct word.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously mid-cycle, in the cycle a CPU read is granted, with starve_cnt = 3.
  - Response: gnt and mem_we drop immediately; no rvalid afterwards. After release, starve_cnt = 0, so debug needs 4 CPU grants before it wins again.
- Dropped debug request:
  - Stimulus: dbg_req high for 2 CPU-won cycles, low for 1 cycle, then high again.
  - Response: counter restarts from 0, and debug is granted only after 4 further CPU grants.
